// File: rtl/led_scan_pkg.sv
// Shared types and defaults for the LED-matrix row-scan receive path.
package led_scan_pkg;

    localparam int unsigned ROWS_DEF = 16;
    localparam int unsigned COLS_DEF = 16;

    // Same plane shape as the grid / LED driver side.
    typedef logic [15:0][15:0] pixel_plane_t;

    typedef enum logic [1:0] {
        SYNC,
        ASSEMBLE,
        PUBLISH
    } rx_state_t;

endpackage

// File: rtl/scan_hold_qualifier.sv
// Registers the scanned {row, red, green} tuple and accepts a row once it has
// been stable and valid for MIN_HOLD consecutive cycles.
module scan_hold_qualifier #(
    parameter int unsigned RW       = 4,
    parameter int unsigned COLS     = 16,
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [RW-1:0]   i_row,
    input  logic [COLS-1:0] i_red,
    input  logic [COLS-1:0] i_grn,
    output logic            o_accept,
    output logic [RW-1:0]   o_row,
    output logic [COLS-1:0] o_red,
    output logic [COLS-1:0] o_grn
);

    localparam logic [7:0] HOLD = 8'(MIN_HOLD);

    logic                   r_prev_valid;
    logic [RW+2*COLS-1:0]   r_prev_tuple;
    logic [7:0]             r_cnt;

    logic [RW+2*COLS-1:0]   w_tuple;
    logic                   w_reload;
    logic [7:0]             w_cnt_next;
    logic                   w_accept;

    assign w_tuple  = {i_row, i_red, i_grn};
    assign w_reload = i_valid && (!r_prev_valid || (w_tuple != r_prev_tuple));

    // Hold counter next value; acceptance fires only on the step that reaches HOLD.
    always_comb begin
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        if (!i_valid) begin
            w_cnt_next = '0;
        end else if (w_reload) begin
            w_cnt_next = 8'd1;
            w_accept   = (HOLD == 8'd1);
        end else if (r_cnt < HOLD) begin
            w_cnt_next = r_cnt + 8'd1;
            w_accept   = (r_cnt == HOLD - 8'd1);
        end
    end

    // Previous-cycle tuple and counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_valid <= 1'b0;
            r_prev_tuple <= '0;
            r_cnt        <= '0;
        end else begin
            r_prev_valid <= i_valid;
            r_prev_tuple <= w_tuple;
            r_cnt        <= w_cnt_next;
        end
    end

    assign o_accept = w_accept;
    assign o_row    = i_row;
    assign o_red    = i_red;
    assign o_grn    = i_grn;

endmodule

// File: rtl/led_scan_receiver.sv
// Row-scan receiver: reassembles qualified rows 0..ROWS-1 into a shadow frame
// and publishes complete red/green planes with a one-cycle frame_done pulse.
module led_scan_receiver
    import led_scan_pkg::*;
#(
    parameter int unsigned ROWS     = ROWS_DEF,
    parameter int unsigned COLS     = COLS_DEF,
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scan_valid,
    input  logic [$clog2(ROWS)-1:0]   scan_row,
    input  logic [COLS-1:0]           scan_red,
    input  logic [COLS-1:0]           scan_grn,
    output logic [ROWS-1:0][COLS-1:0] red_frame,
    output logic [ROWS-1:0][COLS-1:0] grn_frame,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic                      seq_error,
    output logic                      busy
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    logic            w_acc;
    logic [RW-1:0]   w_row;
    logic [COLS-1:0] w_red;
    logic [COLS-1:0] w_grn;

    scan_hold_qualifier #(
        .RW       (RW),
        .COLS     (COLS),
        .MIN_HOLD (MIN_HOLD)
    ) u_qual (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_valid  (scan_valid),
        .i_row    (scan_row),
        .i_red    (scan_red),
        .i_grn    (scan_grn),
        .o_accept (w_acc),
        .o_row    (w_row),
        .o_red    (w_red),
        .o_grn    (w_grn)
    );

    rx_state_t                 r_state, w_state_next;
    logic [RW-1:0]             r_exp, w_exp_next;
    logic [ROWS-1:0][COLS-1:0] r_shadow_red, r_shadow_grn;
    logic [ROWS-1:0][COLS-1:0] r_red_frame, r_grn_frame;
    logic                      r_done;
    logic [15:0]               r_count;
    logic                      r_err;

    // An acceptance landing in PUBLISH (or behind another pending one) is
    // parked for one slot so the FSM sees it on the following cycle.
    logic            r_pend;
    logic [RW-1:0]   r_pend_row;
    logic [COLS-1:0] r_pend_red, r_pend_grn;

    logic            w_ev;
    logic [RW-1:0]   w_ev_row;
    logic [COLS-1:0] w_ev_red, w_ev_grn;
    logic            w_defer;
    logic            w_wr, w_err, w_pub;

    assign w_ev     = (r_state != PUBLISH) && (r_pend || w_acc);
    assign w_ev_row = r_pend ? r_pend_row : w_row;
    assign w_ev_red = r_pend ? r_pend_red : w_red;
    assign w_ev_grn = r_pend ? r_pend_grn : w_grn;
    assign w_defer  = w_acc && ((r_state == PUBLISH) || r_pend);

    // Next-state, expected-row and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_exp_next   = r_exp;
        w_wr         = 1'b0;
        w_err        = 1'b0;
        w_pub        = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_ev && (w_ev_row == '0)) begin
                    w_wr         = 1'b1;
                    w_exp_next   = RW'(1);
                    w_state_next = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (w_ev) begin
                    if (w_ev_row == r_exp) begin
                        w_wr = 1'b1;
                        if (w_ev_row == LAST_ROW) begin
                            w_exp_next   = '0;
                            w_state_next = PUBLISH;
                        end else begin
                            w_exp_next = r_exp + RW'(1);
                        end
                    end else if (w_ev_row == r_exp - RW'(1)) begin
                        w_wr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                        if (w_ev_row == '0) begin
                            w_wr       = 1'b1;
                            w_exp_next = RW'(1);
                        end else begin
                            w_exp_next   = '0;
                            w_state_next = SYNC;
                        end
                    end
                end
            end
            PUBLISH: begin
                w_pub        = 1'b1;
                w_exp_next   = '0;
                w_state_next = SYNC;
            end
            default: begin
                w_exp_next   = '0;
                w_state_next = SYNC;
            end
        endcase
    end

    // State and expected-row registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SYNC;
            r_exp   <= '0;
        end else begin
            r_state <= w_state_next;
            r_exp   <= w_exp_next;
        end
    end

    // Deferred-acceptance slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_pend_row <= '0;
            r_pend_red <= '0;
            r_pend_grn <= '0;
        end else if (w_defer) begin
            r_pend     <= 1'b1;
            r_pend_row <= w_row;
            r_pend_red <= w_red;
            r_pend_grn <= w_grn;
        end else if (r_state != PUBLISH) begin
            r_pend <= 1'b0;
        end
    end

    // Shadow buffer, published planes, frame counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_red <= '0;
            r_shadow_grn <= '0;
            r_red_frame  <= '0;
            r_grn_frame  <= '0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_wr) begin
                r_shadow_red[w_ev_row] <= w_ev_red;
                r_shadow_grn[w_ev_row] <= w_ev_grn;
            end
            if (w_pub) begin
                r_red_frame <= r_shadow_red;
                r_grn_frame <= r_shadow_grn;
                r_count     <= r_count + 16'd1;
            end
            r_done <= w_pub;
            if (w_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign red_frame   = r_red_frame;
    assign grn_frame   = r_grn_frame;
    assign frame_done  = r_done;
    assign frame_count = r_count;
    assign seq_error   = r_err;
    assign busy        = (r_state == ASSEMBLE);

endmodule

// File: tb/tb_led_scan_receiver.sv
// Directed bench for led_scan_receiver (ROWS=COLS=16, MIN_HOLD=4).
module tb_led_scan_receiver;
    import led_scan_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         scan_valid;
    logic [3:0]   scan_row;
    logic [15:0]  scan_red;
    logic [15:0]  scan_grn;
    pixel_plane_t red_frame;
    pixel_plane_t grn_frame;
    logic         frame_done;
    logic [15:0]  frame_count;
    logic         seq_error;
    logic         busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int done_pulses = 0;
    int busy_cycles = 0;
    int d0;
    int b0;
    logic [15:0] fr_red [16];
    logic [15:0] fr_grn [16];

    always #5 clk = ~clk;

    led_scan_receiver #(
        .ROWS     (16),
        .COLS     (16),
        .MIN_HOLD (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_valid  (scan_valid),
        .scan_row    (scan_row),
        .scan_red    (scan_red),
        .scan_grn    (scan_grn),
        .red_frame   (red_frame),
        .grn_frame   (grn_frame),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .seq_error   (seq_error),
        .busy        (busy)
    );

    // Pulse / level monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses++;
        if (busy === 1'b1) busy_cycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic pixel_plane_t plane_of(input logic [15:0] a [16]);
        pixel_plane_t p;
        for (int i = 0; i < 16; i++) p[i] = a[i];
        return p;
    endfunction

    task automatic drive(input int row, input logic [15:0] r, input logic [15:0] g, input int n);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_row   = 4'(row);
        scan_red   = r;
        scan_grn   = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int lo, input int hi, input int n);
        for (int i = lo; i <= hi; i++) drive(i, fr_red[i], fr_grn[i], n);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        scan_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        scan_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        scan_valid = 1'b0;
        scan_row   = '0;
        scan_red   = '0;
        scan_grn   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("reset_red",   red_frame, '0);
        chk("reset_grn",   grn_frame, '0);
        chk("reset_count", frame_count, '0);
        chk("reset_err",   seq_error, 1'b0);
        chk("reset_busy",  busy, 1'b0);
        chk("reset_done",  frame_done, 1'b0);

        // In-order frame with identity diagonal on red, complement on green
        for (int i = 0; i < 16; i++) begin
            fr_red[i] = 16'h0001 << i;
            fr_grn[i] = ~(16'h0001 << i);
        end
        d0 = done_pulses;
        send_rows(0, 0, 4);
        chk("t1_busy_row0", busy, 1'b1);
        send_rows(1, 15, 4);
        chk("t1_done_at_accept", frame_done, 1'b0);
        chk("t1_busy_publish",   busy, 1'b0);
        chk("t1_count_before",   frame_count, 16'd0);
        @(posedge clk); #1;
        chk("t1_done_latency",   frame_done, 1'b1);
        chk("t1_count",          frame_count, 16'd1);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", frame_done, 1'b0);
        chk("t1_red_diag", red_frame, plane_of(fr_red));
        chk("t1_grn_inv",  grn_frame, plane_of(fr_grn));
        chk("t1_err",      seq_error, 1'b0);
        chk("t1_pulses",   done_pulses - d0, 1);

        // Rows held one cycle short of MIN_HOLD never qualify
        idle(2);
        d0 = done_pulses;
        b0 = busy_cycles;
        send_rows(0, 15, 3);
        idle(4);
        chk("t2_no_done",  done_pulses - d0, 0);
        chk("t2_no_busy",  busy_cycles - b0, 0);
        chk("t2_count",    frame_count, 16'd1);

        // Stream starting mid-frame is ignored without error
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fr_red[i] = 16'hA5A5 ^ (16'h1111 * 16'(i));
            fr_grn[i] = 16'h0F0F + 16'(i);
        end
        drive(5, 16'hFFFF, 16'hFFFF, 4);
        chk("t3_busy_row5", busy, 1'b0);
        chk("t3_err_row5",  seq_error, 1'b0);
        d0 = done_pulses;
        send_rows(0, 15, 4);
        idle(3);
        chk("t3_pulses", done_pulses - d0, 1);
        chk("t3_count",  frame_count, 16'd1);
        chk("t3_red",    red_frame, plane_of(fr_red));
        chk("t3_grn",    grn_frame, plane_of(fr_grn));

        // Out-of-order row: sticky error, partial frame discarded
        send_rows(0, 2, 4);
        drive(7, fr_red[7], fr_grn[7], 4);
        chk("t4_err",       seq_error, 1'b1);
        chk("t4_busy",      busy, 1'b0);
        chk("t4_red_keep",  red_frame, plane_of(fr_red));
        for (int i = 0; i < 16; i++) begin
            fr_red[i] = ~(16'h8000 >> i);
            fr_grn[i] = 16'(i) << 4;
        end
        d0 = done_pulses;
        send_rows(0, 15, 4);
        idle(3);
        chk("t4_pulses",    done_pulses - d0, 1);
        chk("t4_err_stick", seq_error, 1'b1);
        chk("t4_red",       red_frame, plane_of(fr_red));
        chk("t4_count",     frame_count, 16'd2);

        // Same row re-held with new data overwrites it
        do_reset();
        for (int i = 0; i < 16; i++) begin
            fr_red[i] = 16'h1234 + 16'(i);
            fr_grn[i] = 16'hFFFF - 16'(i);
        end
        drive(0, 16'hDEAD, fr_grn[0], 4);
        chk("t5_busy_first", busy, 1'b1);
        fr_red[0] = 16'hBEEF;
        drive(0, 16'hBEEF, fr_grn[0], 4);
        chk("t5_err",  seq_error, 1'b0);
        chk("t5_busy", busy, 1'b1);
        send_rows(1, 15, 4);
        idle(3);
        chk("t5_row0",  red_frame[0], 16'hBEEF);
        chk("t5_red",   red_frame, plane_of(fr_red));
        chk("t5_count", frame_count, 16'd1);

        // Asynchronous reset mid-frame clears everything immediately
        drive(0, fr_red[0], fr_grn[0], 4);
        drive(3, fr_red[3], fr_grn[3], 4);
        chk("t6_err_set", seq_error, 1'b1);
        send_rows(0, 8, 4);
        drive(9, fr_red[9], fr_grn[9], 2);
        chk("t6_busy_mid", busy, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_red",   red_frame, '0);
        chk("t6_async_grn",   grn_frame, '0);
        chk("t6_async_count", frame_count, '0);
        chk("t6_async_err",   seq_error, 1'b0);
        chk("t6_async_busy",  busy, 1'b0);
        scan_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_rows(0, 15, 4);
        idle(3);
        chk("t6_count", frame_count, 16'd1);
        chk("t6_red",   red_frame, plane_of(fr_red));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
